clkgen_multi: RTL and testbench

//  Parametrised multi-channel clock-enable generator with lock indication.

---
 rtl/clkgen_pkg.sv | 19 +
 rtl/clkgen_channel.sv | 67 ++++++
 rtl/clkgen_multi.sv | 79 +++++++
 tb/tb_clkgen_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock-enable generator.
// Helpers work on 32-bit values; callers size-cast to their counter width.
package clkgen_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_CH_MAX = 8;
  localparam int CALC_W     = 32;

  // Divisors below 2 cannot produce a two-level clock, so they run as 2.
  function automatic logic [CALC_W-1:0] eff_div(input logic [CALC_W-1:0] div);
    return (div < CALC_W'(2)) ? CALC_W'(2) : div;
  endfunction

  function automatic logic [CALC_W-1:0] clamp_phase(input logic [CALC_W-1:0] ph,
                                                    input logic [CALC_W-1:0] n);
    return (ph > n - CALC_W'(1)) ? n - CALC_W'(1) : ph;
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One divider channel: shadow divisor, free-running counter, registered c/e.
// Outputs are computed from the next count so they line up with the count they describe.
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic             load_i,
  input  logic             e_gate_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             c_o,
  output logic             e_o
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             e_q, e_d;

  logic [CNT_W-1:0] n_cur;
  logic [CNT_W-1:0] n_new;
  logic [CNT_W-1:0] start_cnt;

  assign n_cur     = CNT_W'(eff_div(CALC_W'(div_q)));
  assign n_new     = CNT_W'(eff_div(CALC_W'(div_i)));
  // Restart point is clamped against the divisor being loaded, not the old one.
  assign start_cnt = CNT_W'(clamp_phase(CALC_W'(phase_i), CALC_W'(n_new)));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    c_d   = c_q;
    e_d   = 1'b0;
    if (load_i) begin
      div_d = div_i;
      cnt_d = start_cnt;
      c_d   = 1'b0;
    end else if (ena_i) begin
      cnt_d = (cnt_q >= n_cur - 1'b1) ? '0 : cnt_q + 1'b1;
      c_d   = (cnt_d < (n_cur >> 1));
      e_d   = (cnt_d == n_cur - 1'b1) & e_gate_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= CNT_W'(DIV_DEFAULT);
      cnt_q <= '0;
      c_q   <= 1'b0;
      e_q   <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      c_q   <= c_d;
      e_q   <= e_d;
    end
  end

  assign c_o = c_q;
  assign e_o = e_q;

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel clock-enable generator with lock indication (top level).
// Optional per-channel start offset is compiled in with macro CLKGEN_PHASE_EN.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    inclk0,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
`ifdef CLKGEN_PHASE_EN
  input  logic [NUM_CH*CNT_W-1:0] phase_val,
`endif
  output logic [NUM_CH-1:0]       c,
  output logic [NUM_CH-1:0]       e,
  output logic                    locked
);

  localparam int LK_W = $clog2(LOCK_CYCLES + 1);

  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;
  logic [NUM_CH*CNT_W-1:0] phase_bus;

`ifdef CLKGEN_PHASE_EN
  assign phase_bus = phase_val;
`else
  assign phase_bus = '0;
`endif

  // Lock counter runs independently of ena and saturates at LOCK_CYCLES.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (cfg_load) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      if (lock_cnt_q != LK_W'(LOCK_CYCLES)) lock_cnt_d = lock_cnt_q + 1'b1;
      locked_d = locked_q | (lock_cnt_d == LK_W'(LOCK_CYCLES));
    end
  end

  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;

  // Strobes are gated by the next lock state so e and locked rise on the same edge.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkgen_channel #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .clk_i    (inclk0),
      .rst_ni   (rst_n),
      .ena_i    (ena),
      .load_i   (cfg_load),
      .e_gate_i (locked_d),
      .div_i    (div_val[i*CNT_W +: CNT_W]),
      .phase_i  (phase_bus[i*CNT_W +: CNT_W]),
      .c_o      (c[i]),
      .e_o      (e[i])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: default two channels, 16-bit counters, lock after 16.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_clkgen_multi;

  logic        inclk0 = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        cfg_load;
  logic [31:0] div_val;
`ifdef CLKGEN_PHASE_EN
  logic [31:0] phase_val;
`endif
  logic [1:0]  c;
  logic [1:0]  e;
  logic        locked;

  int n_pass = 0;
  int n_chk  = 0;

  logic [1:0] t2_c [0:9];

  clkgen_multi dut (
    .inclk0   (inclk0),
    .rst_n    (rst_n),
    .ena      (ena),
    .cfg_load (cfg_load),
    .div_val  (div_val),
`ifdef CLKGEN_PHASE_EN
    .phase_val(phase_val),
`endif
    .c        (c),
    .e        (e),
    .locked   (locked)
  );

  always #5 inclk0 = ~inclk0;

  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // {c1,c0} for cycles 1..10 after loading ch0=5, ch1=4
    t2_c = '{2'd3, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1};

    rst_n    = 1'b0;
    ena      = 1'b1;
    cfg_load = 1'b0;
    div_val  = '0;
`ifdef CLKGEN_PHASE_EN
    phase_val = '0;
`endif
    run(2);
    check("rst_c", c, 0);
    check("rst_e", e, 0);
    check("rst_locked", locked, 0);

    // Default divisor 2: c toggles, e held off until lock at cycle 16
    rst_n = 1'b1;
    tick();
    check("t1_c_k1", c, 2'b00);
    tick();
    check("t1_c_k2", c, 2'b11);
    run(13);
    check("t1_locked_k15", locked, 0);
    check("t1_e_k15", e, 2'b00);
    tick();
    check("t1_locked_k16", locked, 1);
    check("t1_e_k16", e, 2'b00);
    tick();
    check("t1_e_k17", e, 2'b11);
    check("t1_c_k17", c, 2'b00);
    tick();
    check("t1_e_k18", e, 2'b00);

    // ch0=5, ch1=4
    div_val  = {16'd4, 16'd5};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("t2_load_c", c, 2'b00);
    check("t2_load_locked", locked, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t2_c_k%0d", k), c, t2_c[k-1]);
    end
    run(5);
    check("t2_locked_k15", locked, 0);
    tick();
    check("t2_locked_k16", locked, 1);
    check("t2_e_k16", e, 2'b00);
    run(3);
    check("t2_e_k19", e, 2'b11);
    tick();
    check("t2_e_k20", e, 2'b00);
    check("t2_c_k20", c, 2'b11);
    run(4);
    check("t2_e_k24", e, 2'b01);
    check("t2_c_k24", c, 2'b10);

    // cfg_load with ena=0, then a second load on the next cycle wins
    ena      = 1'b0;
    div_val  = {16'd2, 16'd7};
    cfg_load = 1'b1;
    tick();
    check("ld_ena0_locked", locked, 0);
    check("ld_ena0_c", c, 2'b00);
    div_val = {16'd2, 16'd3};
    tick();
    cfg_load = 1'b0;
    ena      = 1'b1;
    run(2);
    check("ld_last_c_k2", c, 2'b10);
    tick();
    check("ld_last_c_k3", c, 2'b01);

    // div 0 and 1 behave as 2
    div_val  = {16'd1, 16'd0};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    check("t3_c_k1", c, 2'b00);
    tick();
    check("t3_c_k2", c, 2'b11);
    tick();
    check("t3_c_k3", c, 2'b00);
    run(14);
    check("t3_e_k17", e, 2'b11);
    tick();
    check("t3_e_k18", e, 2'b00);

    // ch0 at 65535: high half ends at 32767, strobe at 65534, wrap to 0
    div_val  = {16'd2, 16'hFFFF};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    run(32766);
    check("t3_c0_k32766", c[0], 1);
    tick();
    check("t3_c0_k32767", c[0], 0);
    run(32766);
    check("t3_e_k65533", e, 2'b10);
    tick();
    check("t3_e_k65534", e, 2'b01);
    check("t3_c0_k65534", c[0], 0);
    tick();
    check("t3_e_k65535", e, 2'b10);
    check("t3_c0_k65535", c[0], 1);

    // N=10, pause at cnt=3 for 7 cycles
    div_val  = {16'd10, 16'd10};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    run(23);
    check("t4_c_cnt3", c, 2'b11);
    check("t4_locked", locked, 1);
    ena = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("t4_hold_ce_%0d", k), {c, e}, 4'b1100);
    end
    check("t4_locked_hold", locked, 1);
    ena = 1'b1;
    run(5);
    check("t4_e_resume5", e, 2'b00);
    check("t4_c_resume5", c, 2'b00);
    tick();
    check("t4_e_resume6", e, 2'b11);
    run(9);
    ena = 1'b0;
    tick();
    check("t4_e_pause_cnt8", e, 2'b00);
    check("t4_c_pause_cnt8", c, 2'b00);
    ena = 1'b1;
    tick();
    check("t4_e_after_pause", e, 2'b11);

    // Reset mid-period, then reset together with cfg_load
    run(3);
    rst_n = 1'b0;
    tick();
    check("t5_rst_ce", {c, e}, 4'b0000);
    check("t5_rst_locked", locked, 0);
    div_val  = {16'd5, 16'd5};
    cfg_load = 1'b1;
    tick();
    check("t5_rstld_ce", {c, e}, 4'b0000);
    check("t5_rstld_locked", locked, 0);
    rst_n    = 1'b1;
    cfg_load = 1'b0;
    tick();
    check("t5_c_k1", c, 2'b00);
    tick();
    check("t5_c_k2", c, 2'b11);
    run(13);
    check("t5_locked_k15", locked, 0);
    tick();
    check("t5_locked_k16", locked, 1);
    tick();
    check("t5_e_k17", e, 2'b11);

`ifdef CLKGEN_PHASE_EN
    // N=8, ch1 starts at 3, so its strobe leads ch0 by 3 cycles
    div_val   = {16'd8, 16'd8};
    phase_val = {16'd3, 16'd0};
    cfg_load  = 1'b1;
    tick();
    cfg_load = 1'b0;
    run(20);
    check("t6_e_k20", e, 2'b10);
    run(3);
    check("t6_e_k23", e, 2'b01);
    // phase 20 clamps to 7
    phase_val = {16'd20, 16'd0};
    cfg_load  = 1'b1;
    tick();
    cfg_load = 1'b0;
    run(4);
    check("t6_clamp_c_k4", c, 2'b10);
    tick();
    check("t6_clamp_c_k5", c, 2'b00);
    run(11);
    check("t6_clamp_e_k16", e, 2'b10);
    check("t6_clamp_locked", locked, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
